// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline types and constants
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  // r15 is the PC and lives outside the register file.
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB bus and register-file write port
interface wb_stage_if;
  import arm_pkg::*;

  // MEM stage side
  logic              mem_valid;
  logic              WB_EN_in;
  logic              MEM_R_EN_in;
  logic [DATA_W-1:0] ALU_Res_in;
  logic [REG_W-1:0]  Dest_in;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              freeze;

  // register-file write port
  logic              writebackEn;
  logic [REG_W-1:0]  Dest_WB;
  logic [DATA_W-1:0] Result_WB;

  // the write-back stage itself
  modport slave (
    input  mem_valid, WB_EN_in, MEM_R_EN_in, ALU_Res_in, Dest_in,
    input  mem_rdata, mem_rvalid,
    output freeze, writebackEn, Dest_WB, Result_WB
  );

  // pipeline / memory / register file around it
  modport master (
    output mem_valid, WB_EN_in, MEM_R_EN_in, ALU_Res_in, Dest_in,
    output mem_rdata, mem_rvalid,
    input  freeze, writebackEn, Dest_WB, Result_WB
  );

endinterface

// File: rtl/wb_load_timer.sv
// rtl/wb_load_timer.sv - load wait timer with terminal count
module wb_load_timer #(
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  logic [W-1:0] count;

  // clear wins over enable so a freshly accepted load always starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(LOAD_TIMEOUT - 1));

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - ARM write-back stage with load wait and retire counter
module wb_stage
  import arm_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        bus,
  output logic             load_timeout_err,
  output logic [CNT_W-1:0] retire_cnt
);

  wb_state_t         state_q, state_d;
  logic              lat_we;
  logic [REG_W-1:0]  lat_dest;

  logic              timer_clr, timer_en, timeout_hit;
  logic              freeze_c;
  logic              latch_load;
  logic              commit_we;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic              retire;
  logic              set_err;

  wb_load_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timeout_hit)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, commit decision and stall request
  always_comb begin
    state_d     = state_q;
    freeze_c    = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    latch_load  = 1'b0;
    commit_we   = 1'b0;
    commit_dest = bus.Dest_in;
    commit_data = bus.ALU_Res_in;
    retire      = 1'b0;
    set_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (bus.MEM_R_EN_in && !bus.mem_rvalid) begin
            // load data not here yet: hold MEM and remember where it goes
            freeze_c   = 1'b1;
            latch_load = 1'b1;
            timer_clr  = 1'b1;
            state_d    = WAIT_LOAD;
          end else begin
            retire      = 1'b1;
            commit_we   = bus.WB_EN_in && (bus.Dest_in != REG_PC);
            commit_data = bus.MEM_R_EN_in ? bus.mem_rdata : bus.ALU_Res_in;
          end
        end
      end

      WAIT_LOAD: begin
        // MEM inputs are the same frozen load; only the latched copy counts
        timer_en    = 1'b1;
        commit_dest = lat_dest;
        commit_data = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          retire    = 1'b1;
          commit_we = lat_we && (lat_dest != REG_PC);
          state_d   = IDLE;
        end else if (timeout_hit) begin
          // abandon the load; it still retires so MEM can move on
          set_err = 1'b1;
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          freeze_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // reset must release the pipeline at once, even while MEM holds a load
  assign bus.freeze = freeze_c && !rst;

  // pending-load capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_dest <= '0;
    end else if (latch_load) begin
      lat_we   <= bus.WB_EN_in;
      lat_dest <= bus.Dest_in;
    end
  end

  // register-file write pulse; index and data hold when no write occurs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.writebackEn <= 1'b0;
      bus.Dest_WB     <= '0;
      bus.Result_WB   <= '0;
    end else begin
      bus.writebackEn <= commit_we;
      if (commit_we) begin
        bus.Dest_WB   <= commit_dest;
        bus.Result_WB <= commit_data;
      end
    end
  end

  // retire counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt       <= '0;
      load_timeout_err <= 1'b0;
    end else begin
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (set_err) begin
        load_timeout_err <= 1'b1;
      end
    end
  end

endmodule
